// File: rtl/mapped_memory_pkg.sv
// mem_map_pkg: shared region/state types, default memory map and address decode
package mem_map_pkg;
  typedef enum logic [1:0] {REG_RAM, REG_SCREEN, REG_KBD, REG_NONE} region_e;
  typedef enum logic {CLEAR, IDLE} state_e;
  localparam int DATA_W_D = 16;
  localparam int ADDR_W_D = 15;
  localparam int RAM_WORDS_D = 16384;
  localparam int SCREEN_BASE_D = 'h4000;
  localparam int SCREEN_WORDS_D = 8192;
  localparam int KBD_ADDR_D = 'h6000;
  function automatic region_e decode(input int unsigned a, ram_words, screen_base, screen_words, kbd_addr);
    return a < ram_words ? REG_RAM :
           (a >= screen_base && a < screen_base + screen_words) ? REG_SCREEN :
           a == kbd_addr ? REG_KBD : REG_NONE;
  endfunction
endpackage

// File: rtl/mapped_memory_if.sv
// mapped_memory_if: CPU data-port bus with request/ready handshake and valid-strobed reads
interface mapped_memory_if import mem_map_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
);
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic [ADDR_W-1:0] address;
  logic load;
  logic req;
  logic ready;
  logic out_valid;
  modport master(output in, address, load, req, input ready, out, out_valid);
  modport slave(input in, address, load, req, output ready, out, out_valid);
endinterface

// File: rtl/mapped_memory_bank.sv
// mem_bank: synchronous single-port RAM with registered read data
module mem_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16384,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // write commits at the edge; read data appears after the same edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mapped_memory.sv
// mapped_memory: memory-mapped RAM/screen/keyboard store with clear-after-reset and error flag
module mapped_memory import mem_map_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int RAM_WORDS = RAM_WORDS_D,
  parameter int SCREEN_BASE = SCREEN_BASE_D,
  parameter int SCREEN_WORDS = SCREEN_WORDS_D,
  parameter int KBD_ADDR = KBD_ADDR_D,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  mapped_memory_if.slave    bus,
  input  logic [DATA_W-1:0] kbd_code,
  input  logic              kbd_strobe,
  output logic              err,
  input  logic              err_clr
);
  localparam int TOTAL = RAM_WORDS + SCREEN_WORDS;
  localparam int CW = $clog2(TOTAL);
  localparam int RA = RAM_WORDS > 1 ? $clog2(RAM_WORDS) : 1;
  localparam int SA = SCREEN_WORDS > 1 ? $clog2(SCREEN_WORDS) : 1;
  state_e state, state_nx;
  region_e reg_a, rd_sel;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] kbd, kbd_snap, ram_q, scr_q, wd;
  logic [RA-1:0] ram_a;
  logic [SA-1:0] scr_a;
  logic clearing, acc, rd_pend, err_set, ram_we, scr_we;
  assign clearing = state == CLEAR;
  assign acc = bus.req && bus.ready;
  assign reg_a = decode(32'(bus.address), RAM_WORDS, SCREEN_BASE, SCREEN_WORDS, KBD_ADDR);
  assign err_set = acc && (bus.load ? reg_a inside {REG_KBD, REG_NONE} : reg_a == REG_NONE);
  assign ram_we = clearing ? cnt < CW'(RAM_WORDS) : acc && bus.load && reg_a == REG_RAM;
  assign scr_we = clearing ? cnt >= CW'(RAM_WORDS) : acc && bus.load && reg_a == REG_SCREEN;
  assign ram_a = clearing ? RA'(cnt) : RA'(bus.address);
  assign scr_a = clearing ? SA'(cnt - CW'(RAM_WORDS)) : SA'(bus.address - ADDR_W'(SCREEN_BASE));
  assign wd = clearing ? '0 : bus.in;
  mem_bank #(.WIDTH(DATA_W), .DEPTH(RAM_WORDS)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_a), .wdata(wd), .rdata(ram_q)
  );
  mem_bank #(.WIDTH(DATA_W), .DEPTH(SCREEN_WORDS)) u_screen (
    .clk(clk), .we(scr_we), .addr(scr_a), .wdata(wd), .rdata(scr_q)
  );
  // state register: reset re-enters the clear sweep when enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    else state <= state_nx;
  // leave CLEAR after the last word; only IDLE accepts requests
  always_comb begin
    state_nx = clearing && cnt == CW'(TOTAL - 1) ? IDLE : state;
    bus.ready = state == IDLE;
  end
  // clear address counter saturates at the last word instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clearing && cnt != CW'(TOTAL - 1)) cnt <= cnt + 1'b1;
  // keyboard register latches on strobe in every state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) kbd <= '0;
    else if (kbd_strobe) kbd <= kbd_code;
  // first read stage: remember region and the pre-strobe keyboard value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_sel <= REG_NONE;
      kbd_snap <= '0;
    end else begin
      rd_pend <= acc && !bus.load;
      rd_sel <= reg_a;
      kbd_snap <= kbd;
    end
  // second read stage: select the source and pulse out_valid; out holds otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= rd_pend;
      if (rd_pend) bus.out <= rd_sel == REG_RAM ? ram_q : rd_sel == REG_SCREEN ? scr_q : rd_sel == REG_KBD ? kbd_snap : '0;
    end
  // sticky error; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else err <= err_set || (err && !err_clr);
endmodule

// File: tb/tb_mapped_memory.sv
// tb_mapped_memory: scoreboard bench for mapped_memory with a small memory map
module tb_mapped_memory;
  localparam logic [14:0] SB = 15'h4000;
  localparam logic [14:0] KA = 15'h6000;
  logic clk = 0;
  logic rst_n = 0;
  logic [15:0] kbd_code = '0;
  logic kbd_strobe = 0;
  logic err_clr = 0;
  logic err;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m[24];
  int n;
  mapped_memory_if bus();
  mapped_memory #(.RAM_WORDS(16), .SCREEN_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .kbd_code(kbd_code),
    .kbd_strobe(kbd_strobe), .err(err), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // pop the oldest expected read whenever the DUT presents a result
  always @(negedge clk)
    if (bus.out_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else check("rd_data", 32'(bus.out), 32'(exp_q.pop_front()));
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    bus.req = 1; bus.load = 1; bus.address = a; bus.in = d;
    step();
    bus.req = 0; bus.load = 0;
  endtask
  task automatic rd(input logic [14:0] a, input logic [15:0] e);
    bus.req = 1; bus.load = 0; bus.address = a;
    exp_q.push_back(e);
    step();
    bus.req = 0;
  endtask
  task automatic settle();
    repeat (2) step();
  endtask
  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 100) begin
      step();
      cnt++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.req = 0; bus.load = 0; bus.address = '0; bus.in = '0;
    repeat (3) step();
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    rst_n = 1;
    n = 0;
    while (!bus.ready && n < 100) begin
      bus.req = n >= 6; bus.load = n < 12; bus.address = 15'd3; bus.in = 16'h1234;
      step();
      n++;
    end
    bus.req = 0; bus.load = 0;
    check("clear_len", n, 32'd24);
    rd(15'd3, 16'h0000);
    settle();
    check("valid_pulse", 32'(bus.out_valid), 32'd0);
    wr(15'd0, 16'hABAB);
    rd(15'd0, 16'hABAB);
    settle();
    check("out_hold", 32'(bus.out), 32'hABAB);
    bus.req = 0; bus.load = 1; bus.address = 15'd0; bus.in = 16'h1111;
    step();
    bus.load = 0;
    rd(15'd0, 16'hABAB);
    wr(SB, 16'hCDCD);
    rd(SB, 16'hCDCD);
    settle();
    check("err_before_kbd_wr", 32'(err), 32'd0);
    wr(KA, 16'hABAB);
    check("err_kbd_wr", 32'(err), 32'd1);
    rd(KA, 16'h0000);
    settle();
    err_clr = 1;
    step();
    err_clr = 0;
    check("err_cleared", 32'(err), 32'd0);
    kbd_code = 16'h0041; kbd_strobe = 1;
    rd(KA, 16'h0000);
    kbd_strobe = 0;
    rd(KA, 16'h0041);
    settle();
    check("err_kbd_rd", 32'(err), 32'd0);
    rd(KA + 15'd1, 16'h0000);
    settle();
    check("err_unmapped_rd", 32'(err), 32'd1);
    err_clr = 1;
    rd(KA + 15'd1, 16'h0000);
    err_clr = 0;
    check("err_set_wins", 32'(err), 32'd1);
    settle();
    err_clr = 1;
    step();
    err_clr = 0;
    check("err_cleared2", 32'(err), 32'd0);
    wr(15'd16, 16'h5555);
    check("err_unmapped_wr", 32'(err), 32'd1);
    err_clr = 1;
    step();
    err_clr = 0;
    for (int i = 0; i < 24; i++) begin
      m[i] = 16'($urandom);
      wr(i < 16 ? 15'(i) : SB + 15'(i - 16), m[i]);
    end
    for (int i = 0; i < 24; i++) rd(i < 16 ? 15'(i) : SB + 15'(i - 16), m[i]);
    settle();
    check("err_after_burst", 32'(err), 32'd0);
    wr(KA, 16'h0000);
    bus.req = 1; bus.load = 0; bus.address = 15'd0;
    step();
    bus.req = 0;
    rst_n = 0;
    #1;
    check("midrd_valid", 32'(bus.out_valid), 32'd0);
    check("midrd_out", 32'(bus.out), 32'd0);
    check("midrd_err", 32'(err), 32'd0);
    check("midrd_ready", 32'(bus.ready), 32'd0);
    settle();
    rst_n = 1;
    repeat (10) step();
    check("midclear_busy", 32'(bus.ready), 32'd0);
    rst_n = 0;
    #1;
    check("midclear_rst_ready", 32'(bus.ready), 32'd0);
    step();
    rst_n = 1;
    wait_clear(n);
    check("reclear_len", n, 32'd24);
    rd(15'd5, 16'h0000);
    rd(SB + 15'd7, 16'h0000);
    rd(KA, 16'h0000);
    settle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
